trivia_stream_top: RTL
======================

# trivia_stream_top

Parametrised, streaming successor of the TriviA-ck top-level datapath. Consumes associated data and message beats over valid/ready handshakes, XORs message blocks with an externally generated keystream, masks partial final blocks at byte granularity, folds every absorbed block into a rotating tag accumulator, and emits or verifies the final tag. It sits between the system memory/stream fabric and the keystream generator (load_SC-class block), replacing the fixed 64-bit, memory-strobed top.

## Interface
- DATA_W, 64, block/beat width in bits; multiple of 32, 32..256.
- TAG_W, 128, tag width; integer multiple of DATA_W.
- LEN_W, 64, width of length fields in bytes.
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to begin a packet; honoured only in IDLE.
- enc_dec  in  1  0 encrypt, 1 decrypt; sampled with start.
- ad_len, msg_len  in  LEN_W  byte lengths; sampled with start.
- in_data  in  DATA_W  AD beats, then message beats; byte i at bits [DATA_W-1-8i -: 8].
- in_valid / in_ready  in / out  1  input handshake.
- ks_data  in  DATA_W  keystream word.
- ks_valid / ks_ready  in / out  1  keystream handshake.
- tag_in  in  TAG_W  expected tag (decrypt); sampled when TAG phase completes.
- out_data  out  DATA_W  ciphertext/plaintext beat, then tag beats (encrypt only).
- out_keep  out  DATA_W/8  byte enables; bit DATA_W/8-1 is byte 0.
- out_valid / out_ready  out / in  1  output handshake; out_last marks final beat.
- tag_out  out  TAG_W  computed tag, held until next start.
- done  out  1  one-cycle pulse at packet end.
- auth_ok  out  1  decrypt: tag_out == tag_in; encrypt: 1. Held until next start.
- busy  out  1  high outside IDLE.
- clen  out  LEN_W  bytes emitted on out_* this packet.

## Operation
- States: IDLE -> AD (if ad_len!=0) -> MSG (if msg_len!=0) -> TAG -> FIN -> IDLE. Zero-length phases skipped on the same transition.
- Block counts: nb = ceil(len/(DATA_W/8)); last block holds r = len mod (DATA_W/8) bytes (r=0 means full). Bytes past len are forced to zero in the padded block P.
- AD: in_ready=1, ks_ready=0. Each accepted beat: T <= rotl1(T) ^ zext(P). No output.
- MSG: beat fires when in_valid & ks_valid & (~out_valid | out_ready); in_ready = ks_ready = that condition. Y = (in_data ^ ks_data) masked. Encrypt: P = masked in_data; decrypt: P = Y. T <= rotl1(T) ^ zext(P). out_data=Y, out_keep per length, out_last = last block and decrypt.
- TAG: ks_ready=1 for TAG_W/DATA_W words K0..Kn-1 (gated by output space in encrypt). Tag = T ^ {K0,...,Kn-1}, K0 most significant. Encrypt: each tag word also emitted (Ti ^ Ki) with full keep, out_last on final word.
- FIN: waits for output buffer to drain; then tag_out, auth_ok valid, done pulses, back to IDLE.
- clen += popcount(out_keep) on each out handshake; cleared on start.
- T cleared on start. start while busy ignored.

## Timing
- Output is a single registered stage: data appears the cycle after the firing beat; out_data/keep/last stable while out_valid & ~out_ready.
- Full-rate: one beat per cycle when all valids high and out_ready=1.
- FIN to done: 1 cycle after last output handshake (or after last ks word in decrypt).
- Reset (reset=0 at clock edge, any state including mid-packet): state IDLE, T=0, out_valid=0, out_keep=0, out_data=0, out_last=0, in_ready=0, ks_ready=0, done=0, auth_ok=0, busy=0, clen=0, tag_out=0. Partial packet discarded.
- start and reset same edge: reset wins.

## Test plan
- DATA_W=64, ad_len=8, in_data=0x0000000000000001, msg_len=0, K0=K1=0 -> no msg output, tag_out=128'h1, done one pulse, clen=16 (encrypt).
- Encrypt msg_len=3, ad_len=0, in_data=0xAABBCC1122334455, ks=all ones -> out_data=0x5544330000000000, out_keep=8'b11100000, clen after tag=19.
- Decrypt of previous ciphertext with matching tag_in -> plaintext 0xAABBCC..., auth_ok=1; flip one tag_in bit -> auth_ok=0.
- Random out_ready/ks_valid throttling over 37-byte msg, 20-byte AD -> output bit-identical to full-rate run, no beat lost/duplicated, keep stable under stall.
- reset low mid-MSG, then new start -> all outputs at reset values, new packet result equals standalone run.
- start pulsed while busy -> ignored, packet result unchanged; DATA_W=128, TAG_W=256 run of scenario 1 -> tag_out=1.

Source files
------------

// File: rtl/trivia_stream_top_if.sv
// rtl/trivia_stream_top_if.sv - stream bundle for trivia_stream_top: input, keystream and output handshakes
// Ports (signals):
//   in_data/in_valid/in_ready      : AD then message beats into the datapath
//   ks_data/ks_valid/ks_ready      : keystream words from the keystream generator
//   out_data/out_keep/out_valid/out_ready/out_last : ciphertext/plaintext then tag beats
// Modports: slave = datapath side, master = fabric/environment side.
interface trivia_stream_top_if #(
  parameter int DATA_W = 64
);
  logic [DATA_W-1:0]   in_data;
  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   ks_data;
  logic                ks_valid;
  logic                ks_ready;
  logic [DATA_W-1:0]   out_data;
  logic [DATA_W/8-1:0] out_keep;
  logic                out_valid;
  logic                out_ready;
  logic                out_last;

  modport slave (
    input  in_data, in_valid, ks_data, ks_valid, out_ready,
    output in_ready, ks_ready, out_data, out_keep, out_valid, out_last
  );

  modport master (
    output in_data, in_valid, ks_data, ks_valid, out_ready,
    input  in_ready, ks_ready, out_data, out_keep, out_valid, out_last
  );
endinterface

// File: rtl/trivia_stream_top.sv
// rtl/trivia_stream_top.sv - streaming TriviA-ck datapath: keystream XOR, byte masking, rotating tag fold
// Ports:
//   clk, reset (sync, active-low)
//   start, enc_dec, ad_len, msg_len : packet request, sampled in IDLE
//   tag_in                          : expected tag for decrypt, sampled at end of TAG
//   s (trivia_stream_top_if.slave)  : input, keystream and output streams
//   tag_out, auth_ok                : result, held until next start
//   done, busy, clen                : end pulse, activity, output byte count
module trivia_stream_top #(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 128,
  parameter int LEN_W  = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                enc_dec,
  input  logic [LEN_W-1:0]    ad_len,
  input  logic [LEN_W-1:0]    msg_len,
  input  logic [TAG_W-1:0]    tag_in,
  trivia_stream_top_if.slave  s,
  output logic [TAG_W-1:0]    tag_out,
  output logic                done,
  output logic                auth_ok,
  output logic                busy,
  output logic [LEN_W-1:0]    clen
);
  localparam int BYTES = DATA_W / 8;
  localparam int NTW   = TAG_W / DATA_W;
  localparam int BW    = $clog2(BYTES + 1);
  localparam int IW    = $clog2(NTW + 1);

  typedef enum logic [2:0] {S_IDLE, S_AD, S_MSG, S_TAG, S_FIN} state_t;

  state_t            state;
  logic              enc_dec_r;
  logic [LEN_W-1:0]  rem;
  logic [LEN_W-1:0]  msg_rem;
  logic [TAG_W-1:0]  t_acc;
  logic [TAG_W-1:0]  tag_in_r;
  logic [IW-1:0]     tw_idx;

  logic              out_space;
  logic              is_last;
  logic [BW-1:0]     nbytes;
  logic [BYTES-1:0]  keep_mask;
  logic [DATA_W-1:0] byte_mask;
  logic [DATA_W-1:0] y_msg;
  logic [DATA_W-1:0] p_blk;
  logic [DATA_W-1:0] tag_word;
  logic [TAG_W-1:0]  t_absorb;
  logic [BW-1:0]     keep_cnt;
  logic              ad_fire;
  logic              msg_fire;
  logic              tag_fire;
  int                tw_base;

  // The output register can take a new beat when empty or draining this cycle.
  assign out_space = ~s.out_valid | s.out_ready;
  assign is_last   = (rem <= LEN_W'(BYTES));
  assign nbytes    = is_last ? rem[BW-1:0] : BW'(BYTES);
  // Byte 0 sits at the MSB end, so valid bytes form a run of ones from the top.
  assign keep_mask = ~({BYTES{1'b1}} >> nbytes);

  always_comb begin
    byte_mask = '0;
    for (int i = 0; i < BYTES; i++) begin
      byte_mask[8*i +: 8] = {8{keep_mask[i]}};
    end
  end

  assign y_msg = (s.in_data ^ s.ks_data) & byte_mask;
  // Decrypt absorbs the recovered plaintext; encrypt absorbs the masked input.
  assign p_blk = (state == S_MSG && enc_dec_r) ? y_msg : (s.in_data & byte_mask);
  assign t_absorb = {t_acc[TAG_W-2:0], t_acc[TAG_W-1]} ^ TAG_W'(p_blk);

  always_comb begin
    tw_base  = TAG_W - DATA_W * (int'(tw_idx) + 1);
    tag_word = t_acc[tw_base +: DATA_W] ^ s.ks_data;
  end

  assign ad_fire  = (state == S_AD) && s.in_valid;
  assign msg_fire = (state == S_MSG) && s.in_valid && s.ks_valid && out_space;
  assign tag_fire = (state == S_TAG) && s.ks_valid && (enc_dec_r || out_space);

  always_comb begin
    s.in_ready = 1'b0;
    s.ks_ready = 1'b0;
    case (state)
      S_AD:  s.in_ready = 1'b1;
      S_MSG: begin
        s.in_ready = msg_fire;
        s.ks_ready = msg_fire;
      end
      S_TAG: s.ks_ready = enc_dec_r | out_space;
      default: ;
    endcase
  end

  always_comb begin
    keep_cnt = '0;
    for (int i = 0; i < BYTES; i++) begin
      keep_cnt = keep_cnt + BW'(s.out_keep[i]);
    end
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      enc_dec_r   <= 1'b0;
      rem         <= '0;
      msg_rem     <= '0;
      t_acc       <= '0;
      tag_in_r    <= '0;
      tw_idx      <= '0;
      s.out_data  <= '0;
      s.out_keep  <= '0;
      s.out_valid <= 1'b0;
      s.out_last  <= 1'b0;
      tag_out     <= '0;
      done        <= 1'b0;
      auth_ok     <= 1'b0;
      clen        <= '0;
    end else begin
      done <= 1'b0;
      if (s.out_valid && s.out_ready) begin
        s.out_valid <= 1'b0;
        clen        <= clen + LEN_W'(keep_cnt);
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            enc_dec_r <= enc_dec;
            t_acc     <= '0;
            clen      <= '0;
            tag_out   <= '0;
            auth_ok   <= 1'b0;
            msg_rem   <= msg_len;
            tw_idx    <= '0;
            if (ad_len != '0) begin
              rem   <= ad_len;
              state <= S_AD;
            end else if (msg_len != '0) begin
              rem   <= msg_len;
              state <= S_MSG;
            end else begin
              state <= S_TAG;
            end
          end
        end
        S_AD: begin
          if (ad_fire) begin
            t_acc <= t_absorb;
            rem   <= rem - LEN_W'(nbytes);
            if (is_last) begin
              if (msg_rem != '0) begin
                rem   <= msg_rem;
                state <= S_MSG;
              end else begin
                state <= S_TAG;
              end
            end
          end
        end
        S_MSG: begin
          if (msg_fire) begin
            t_acc       <= t_absorb;
            rem         <= rem - LEN_W'(nbytes);
            s.out_data  <= y_msg;
            s.out_keep  <= keep_mask;
            s.out_last  <= is_last && enc_dec_r;
            s.out_valid <= 1'b1;
            if (is_last) state <= S_TAG;
          end
        end
        S_TAG: begin
          if (tag_fire) begin
            // The accumulator slice becomes the finished tag word in place.
            t_acc[tw_base +: DATA_W] <= tag_word;
            tw_idx <= tw_idx + 1'b1;
            if (!enc_dec_r) begin
              s.out_data  <= tag_word;
              s.out_keep  <= '1;
              s.out_last  <= (tw_idx == IW'(NTW - 1));
              s.out_valid <= 1'b1;
            end
            if (tw_idx == IW'(NTW - 1)) begin
              tag_in_r <= tag_in;
              state    <= S_FIN;
            end
          end
        end
        S_FIN: begin
          if (out_space) begin
            done    <= 1'b1;
            tag_out <= t_acc;
            auth_ok <= enc_dec_r ? (t_acc == tag_in_r) : 1'b1;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
